// File: rtl/mul_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mul_seq : sequential shift-add multiplier, signed/unsigned, overflow flag |
// | Option  : MUL_EARLY_EXIT_EN ends RUN once the remaining multiplier is 0   |
// | Rev 1.0 : initial release                                                |
// +--------------------------------------------------------------------------+
module mul_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             sign,
  output logic [WIDTH-1:0] result,
  output logic             error,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] c_last_cnt = CW'(WIDTH - 1);
  // 2^(WIDTH-1): the largest magnitude a negative signed result may have
  localparam logic [2*WIDTH-1:0] c_smin_mag = {{WIDTH{1'b0}}, 1'b1, {(WIDTH-1){1'b0}}};
`ifdef MUL_EARLY_EXIT_EN
  localparam bit c_early_exit = 1'b1;
`else
  localparam bit c_early_exit = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [WIDTH-1:0]   r_ma;
  logic [WIDTH-1:0]   r_mb;
  logic [2*WIDTH-1:0] r_acc;
  logic [CW-1:0]      r_cnt;
  logic               r_neg;
  logic               r_sign;

  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;
  logic [2*WIDTH-1:0] w_addend;
  logic [2*WIDTH-1:0] w_prod;
  logic               w_ovf;
  logic               w_last;

  // -32768 negates to itself, which is exactly its unsigned magnitude
  assign w_mag_a  = (sign && A[WIDTH-1]) ? -A : A;
  assign w_mag_b  = (sign && B[WIDTH-1]) ? -B : B;
  assign w_addend = {{WIDTH{1'b0}}, r_ma} << r_cnt;
  assign w_prod   = r_neg ? -r_acc : r_acc;
  assign w_ovf    = r_sign ? (r_neg ? (r_acc > c_smin_mag) : (r_acc >= c_smin_mag))
                           : (|r_acc[2*WIDTH-1:WIDTH]);
  assign w_last   = (r_cnt == c_last_cnt) || (c_early_exit && (r_mb[WIDTH-1:1] == '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start)  w_next = S_RUN;
      S_RUN:   if (w_last) w_next = S_FIX;
      S_FIX:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ma   <= '0;
      r_mb   <= '0;
      r_acc  <= '0;
      r_cnt  <= '0;
      r_neg  <= 1'b0;
      r_sign <= 1'b0;
      result <= '0;
      error  <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_ma   <= w_mag_a;
            r_mb   <= w_mag_b;
            r_neg  <= sign & (A[WIDTH-1] ^ B[WIDTH-1]);
            r_sign <= sign;
            r_acc  <= '0;
            r_cnt  <= '0;
            busy   <= 1'b1;
          end
        end
        S_RUN: begin
          if (r_mb[0]) r_acc <= r_acc + w_addend;
          r_mb  <= r_mb >> 1;
          r_cnt <= r_cnt + 1'b1;
        end
        S_FIX: begin
          result <= w_prod[WIDTH-1:0];
          error  <= w_ovf;
          done   <= 1'b1;
          busy   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mul_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mul_seq : self-checking bench for mul_seq against an arithmetic model  |
// | Rev 1.0    : initial release                                             |
// +--------------------------------------------------------------------------+
module tb_mul_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        sign = 1'b0;
  logic [15:0] A = '0;
  logic [15:0] B = '0;
  logic [15:0] result;
  logic        error;
  logic        busy;
  logic        done;

  int vectors = 0;
  int miscompares = 0;

  mul_seq #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B), .sign(sign),
    .result(result), .error(error), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Reference: true product via integer arithmetic, latency from multiplier magnitude
  function automatic void model(input logic [15:0] a, input logic [15:0] b, input logic s,
                                output logic [15:0] res, output logic err, output int lat);
    longint p;
    longint mb;
    int k;
    if (s) begin
      p   = longint'($signed(a)) * longint'($signed(b));
      err = (p > 32767) || (p < -32768);
      mb  = longint'($signed(b));
      if (mb < 0) mb = -mb;
    end else begin
      p   = longint'(a) * longint'(b);
      err = (p > 65535);
      mb  = longint'(b);
    end
    res = p[15:0];
    k = 0;
    while ((mb >> k) != 0) k++;
`ifdef MUL_EARLY_EXIT_EN
    lat = ((k < 1) ? 1 : k) + 1;
`else
    lat = 17;
`endif
  endfunction

  // Issues one operation and reports edges from the accepting edge until done (-1 on timeout)
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic s, input bit imm,
                        output int lat, output logic [15:0] res, output logic err);
    if (!imm) @(negedge clk);
    A = a; B = b; sign = s; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1; res = 'x; err = 1'bx;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = i; res = result; err = error;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({busy, done, error, result} !== 19'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: busy=%b done=%b error=%b result=%h, want all zero",
               busy, done, error, result);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    logic [15:0] ta [7] = '{16'd100, 16'hFFF8, 16'd8,  16'd300, 16'd200, 16'h8000, 16'h8000};
    logic [15:0] tb [7] = '{16'd2,   16'd4,    16'hFFFC, 16'd300, 16'd200, 16'd1,  16'hFFFF};
    logic        ts [7] = '{1'b0,    1'b1,     1'b1,   1'b0,    1'b1,    1'b1,     1'b1};
    logic [15:0] er, gr;
    logic        ee, ge;
    int          el, gl;
    for (int i = 0; i < 7; i++) begin
      model(ta[i], tb[i], ts[i], er, ee, el);
      run_op(ta[i], tb[i], ts[i], 1'b0, gl, gr, ge);
      vectors++;
      if (gl !== el || gr !== er || ge !== ee) begin
        miscompares++;
        $display("FAIL directed[%0d] %h*%h s=%b: lat=%0d res=%h err=%b, want lat=%0d res=%h err=%b",
                 i, ta[i], tb[i], ts[i], gl, gr, ge, el, er, ee);
      end
      @(posedge clk); #1;
      vectors++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        miscompares++;
        $display("FAIL done_pulse[%0d]: done=%b busy=%b one cycle later, want 0 0", i, done, busy);
      end
    end
  endtask

  task automatic test_random();
    logic [15:0] a, b, er, gr;
    logic        s, ee, ge;
    int          el, gl;
    for (int i = 0; i < 60; i++) begin
      a = 16'($urandom);
      b = ($urandom_range(0, 2) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
      if ($urandom_range(0, 5) == 0) a = 16'($urandom_range(0, 3));
      s = 1'($urandom);
      model(a, b, s, er, ee, el);
      run_op(a, b, s, 1'b0, gl, gr, ge);
      vectors++;
      if (gl !== el || gr !== er || ge !== ee) begin
        miscompares++;
        $display("FAIL random[%0d] %h*%h s=%b: lat=%0d res=%h err=%b, want lat=%0d res=%h err=%b",
                 i, a, b, s, gl, gr, ge, el, er, ee);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] er, gr;
    logic        ee, ge;
    int          el, gl;
    model(16'd1000, 16'd70, 1'b0, er, ee, el);
    run_op(16'd1000, 16'd70, 1'b0, 1'b0, gl, gr, ge);
    vectors++;
    if (gl !== el || gr !== er || ge !== ee) begin
      miscompares++;
      $display("FAIL b2b_first: lat=%0d res=%h err=%b, want lat=%0d res=%h err=%b",
               gl, gr, ge, el, er, ee);
    end
    model(16'hFF00, 16'h0003, 1'b1, er, ee, el);
    run_op(16'hFF00, 16'h0003, 1'b1, 1'b1, gl, gr, ge);
    vectors++;
    if (gl !== el || gr !== er || ge !== ee) begin
      miscompares++;
      $display("FAIL b2b_second: lat=%0d res=%h err=%b, want lat=%0d res=%h err=%b",
               gl, gr, ge, el, er, ee);
    end
  endtask

  task automatic test_busy_ignore();
    logic [15:0] er1, er2, got;
    logic        ee1, ee2, gerr;
    int          el1, el2, ndone, at, gl;
    model(16'd1234, 16'd56, 1'b0, er1, ee1, el1);
    model(16'd7, 16'd9, 1'b0, er2, ee2, el2);
    @(negedge clk);
    A = 16'd1234; B = 16'd56; sign = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    ndone = 0; at = -1; got = 'x; gerr = 1'bx;
    for (int i = 1; i <= el1; i++) begin
      @(posedge clk); #1;
      if (i == 5) begin A = 16'd7; B = 16'd9; end
      if (done) begin ndone++; at = i; got = result; gerr = error; end
    end
    vectors++;
    if (ndone !== 1 || at !== el1 || got !== er1 || gerr !== ee1) begin
      miscompares++;
      $display("FAIL busy_ignore: dones=%0d at=%0d res=%h err=%b, want 1 at %0d res=%h err=%b",
               ndone, at, got, gerr, el1, er1, ee1);
    end
    @(posedge clk); #1;
    start = 1'b0;
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL accept_in_done_cycle: busy=%b, want 1", busy);
    end
    gl = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (done) begin gl = i; got = result; gerr = error; break; end
    end
    vectors++;
    if (gl !== el2 || got !== er2 || gerr !== ee2) begin
      miscompares++;
      $display("FAIL held_start_second: lat=%0d res=%h err=%b, want lat=%0d res=%h err=%b",
               gl, got, gerr, el2, er2, ee2);
    end
  endtask

  task automatic test_reset_midop();
    logic [15:0] er, gr;
    logic        ee, ge;
    int          el, gl, ndone;
    @(negedge clk);
    A = 16'h1234; B = 16'h0FFF; sign = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({busy, done, error, result} !== 19'd0) begin
      miscompares++;
      $display("FAIL midop_reset: busy=%b done=%b error=%b result=%h, want all zero",
               busy, done, error, result);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    repeat (25) begin
      @(posedge clk); #1;
      if (done || busy) ndone++;
    end
    vectors++;
    if (ndone !== 0) begin
      miscompares++;
      $display("FAIL no_done_after_reset: %0d active cycles, want 0", ndone);
    end
    model(16'd0, 16'd0, 1'b0, er, ee, el);
    run_op(16'd0, 16'd0, 1'b0, 1'b0, gl, gr, ge);
    vectors++;
    if (gl !== el || gr !== er || ge !== ee) begin
      miscompares++;
      $display("FAIL zero_after_reset: lat=%0d res=%h err=%b, want lat=%0d res=%h err=%b",
               gl, gr, ge, el, er, ee);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_busy_ignore();
    test_reset_midop();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
